// File: rtl/lotr_pkg.sv
// Shared types for the LOTR tile: C2F opcodes and the UART command parser
// encodings.
package lotr_pkg;

  typedef enum logic [1:0] {
    WR     = 2'd0,
    RD     = 2'd1,
    RD_RSP = 2'd2
  } t_opcode;

  localparam logic [7:0] UART_CMD_WR = 8'h57;
  localparam logic [7:0] UART_CMD_RD = 8'h52;

  typedef enum logic [2:0] {
    CMD_IDLE     = 3'd0,
    CMD_ADDR     = 3'd1,
    CMD_DATA     = 3'd2,
    CMD_ISSUE    = 3'd3,
    CMD_WAIT_RSP = 3'd4,
    CMD_SEND     = 3'd5
  } t_uart_cmd_state;

  // Byte idx of a word, counted from the most-significant end
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Turns host byte streams ('W'+addr+data, 'R'+addr) into single C2F requests
// and returns read data to the host as four bytes, MSB first.
module uart_cmd_parser
  import lotr_pkg::*;
#(
  parameter logic [1:0]  THREAD_ID    = 2'd0,
  parameter int unsigned BYTE_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  output logic        tx_byte_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic        C2F_ReqValidQ500H,
  output t_opcode     C2F_ReqOpcodeQ500H,
  output logic [1:0]  C2F_ReqThreadIDQ500H,
  output logic [31:0] C2F_ReqAddressQ500H,
  output logic [31:0] C2F_ReqDataQ500H,
  input  logic        C2F_RspStall,
  input  logic        C2F_RspValidQ502H,
  input  t_opcode     C2F_RspOpcodeQ502H,
  input  logic [1:0]  C2F_RspThreadIDQ502H,
  input  logic [31:0] C2F_RspDataQ502H,
  output logic        busy,
  output logic        cmd_err
);

  localparam int unsigned TMO_W = $clog2(BYTE_TIMEOUT + 1);

  t_uart_cmd_state state_q, state_d;
  t_opcode         op_q, op_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            req_valid_q, req_valid_d;
  t_opcode         req_op_q, req_op_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     req_data_q, req_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_byte_q, tx_byte_d;

  logic [31:0] addr_shift_c;
  logic [31:0] data_shift_c;
  logic        rsp_match_c;
  logic        tmo_hit_c;

  assign addr_shift_c = {addr_q[23:0], rx_byte};
  assign data_shift_c = {data_q[23:0], rx_byte};
  assign rsp_match_c  = C2F_RspValidQ502H && (C2F_RspOpcodeQ502H == RD_RSP) &&
                        (C2F_RspThreadIDQ502H == THREAD_ID);
  assign tmo_hit_c    = (tmo_q == TMO_W'(BYTE_TIMEOUT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= CMD_IDLE;
      op_q        <= WR;
      cnt_q       <= 2'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_op_q    <= WR;
      req_addr_q  <= 32'd0;
      req_data_q  <= 32'd0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_op_q    <= req_op_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    req_valid_d = req_valid_q;
    req_op_d    = req_op_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;

    case (state_q)
      CMD_IDLE: begin
        if (rx_byte_valid) begin
          if (rx_byte == UART_CMD_WR) begin
            op_d    = WR;
            cnt_d   = 2'd0;
            tmo_d   = '0;
            state_d = CMD_ADDR;
          end else if (rx_byte == UART_CMD_RD) begin
            op_d    = RD;
            cnt_d   = 2'd0;
            tmo_d   = '0;
            state_d = CMD_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CMD_ADDR: begin
        // An arriving byte takes priority over an expiring timeout
        if (rx_byte_valid) begin
          addr_d = addr_shift_c;
          tmo_d  = '0;
          cnt_d  = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) begin
            if (op_q == WR) begin
              state_d = CMD_DATA;
            end else begin
              state_d     = CMD_ISSUE;
              req_valid_d = 1'b1;
              req_op_d    = RD;
              req_addr_d  = addr_shift_c;
              req_data_d  = 32'd0;
            end
          end
        end else if (tmo_hit_c) begin
          state_d = CMD_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      CMD_DATA: begin
        if (rx_byte_valid) begin
          data_d = data_shift_c;
          tmo_d  = '0;
          cnt_d  = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) begin
            state_d     = CMD_ISSUE;
            req_valid_d = 1'b1;
            req_op_d    = WR;
            req_addr_d  = addr_q;
            req_data_d  = data_shift_c;
          end
        end else if (tmo_hit_c) begin
          state_d = CMD_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      CMD_ISSUE: begin
        if (!C2F_RspStall) begin
          req_valid_d = 1'b0;
          state_d     = (op_q == WR) ? CMD_IDLE : CMD_WAIT_RSP;
        end
      end

      CMD_WAIT_RSP: begin
        if (rsp_match_c) begin
          data_d     = C2F_RspDataQ502H;
          tx_valid_d = 1'b1;
          tx_byte_d  = C2F_RspDataQ502H[31:24];
          cnt_d      = 2'd0;
          state_d    = CMD_SEND;
        end
      end

      CMD_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = CMD_IDLE;
          end else begin
            cnt_d     = 2'(cnt_q + 2'd1);
            tx_byte_d = byte_of(data_q, 2'(cnt_q + 2'd1));
          end
        end
      end

      default: state_d = CMD_IDLE;
    endcase

    // Host bytes cannot be buffered while a command is in flight
    if (rx_byte_valid && (state_q == CMD_ISSUE || state_q == CMD_WAIT_RSP ||
                          state_q == CMD_SEND)) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != CMD_IDLE);
  end

  assign C2F_ReqValidQ500H    = req_valid_q;
  assign C2F_ReqOpcodeQ500H   = req_op_q;
  assign C2F_ReqThreadIDQ500H = THREAD_ID;
  assign C2F_ReqAddressQ500H  = req_addr_q;
  assign C2F_ReqDataQ500H     = req_data_q;
  assign tx_byte_valid        = tx_valid_q;
  assign tx_byte              = tx_byte_q;
  assign busy                 = busy_q;
  assign cmd_err              = err_q;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Terminal command parser between the UART receiver/transmitter and the C2F fabric port of the UART tile. It assembles host byte streams (`W` + 4 address bytes + 4 data bytes, or `R` + 4 address bytes, most-significant byte first) into single C2F requests. For reads it returns the 32-bit response data to the host as 4 bytes. It also recovers from truncated commands with an inter-byte timeout.

## Interface
- `THREAD_ID`, 2'd0: value driven on `C2F_ReqThreadIDQ500H`; read responses are matched against it.
- `BYTE_TIMEOUT`, 20000: idle clocks allowed between command bytes before the partial command is discarded (20000 clocks ≈ 4.6 byte times at 50 MHz/115200).
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `rx_byte_valid` in 1: one-cycle strobe, received byte present.
- `rx_byte` in 8: received byte.
- `tx_byte_valid` out 1: byte offered to the UART transmitter.
- `tx_byte` out 8: byte to transmit.
- `tx_ready` in 1: transmitter accepts; transfer occurs when `tx_byte_valid && tx_ready`.
- `C2F_ReqValidQ500H` out 1: request valid.
- `C2F_ReqOpcodeQ500H` out `t_opcode`: `WR` or `RD`.
- `C2F_ReqThreadIDQ500H` out 2: always `THREAD_ID`.
- `C2F_ReqAddressQ500H` out 32: request address.
- `C2F_ReqDataQ500H` out 32: write data; 0 for `RD`.
- `C2F_RspStall` in 1: fabric cannot accept; request held.
- `C2F_RspValidQ502H` in 1: response valid.
- `C2F_RspOpcodeQ502H` in `t_opcode`: response opcode.
- `C2F_RspThreadIDQ502H` in 2: response thread.
- `C2F_RspDataQ502H` in 32: response data.
- `busy` out 1: state not IDLE.
- `cmd_err` out 1: sticky error flag; cleared only by reset.

## Operation
- States: IDLE, ADDR, DATA, ISSUE, WAIT_RSP, SEND.
- IDLE: `0x57` -> ADDR (op=WR); `0x52` -> ADDR (op=RD); any other byte is dropped and sets `cmd_err`.
- ADDR: 2-bit byte counter; each byte shifts into addr (`addr <= {addr[23:0], rx_byte}`). 4th byte -> DATA if WR, ISSUE if RD.
- DATA: same shifting into data; 4th byte -> ISSUE.
- ISSUE: request outputs valid. If `C2F_RspStall`=0: WR -> IDLE, RD -> WAIT_RSP. If stalled, hold all request outputs unchanged.
- WAIT_RSP: leave only on `C2F_RspValidQ502H && opcode==RD_RSP && tid==THREAD_ID`. Latch data and go to SEND. Non-matching responses are ignored. No timeout in this state.
- SEND: offer data[31:24], [23:16], [15:8], [7:0] in order; advance on each `tx_byte_valid && tx_ready`. After the 4th byte -> IDLE.
- Bytes arriving in ISSUE, WAIT_RSP or SEND are dropped and set `cmd_err`.
- Timeout: counter clears on every accepted byte and counts while in ADDR or DATA. On reaching `BYTE_TIMEOUT`: -> IDLE, set `cmd_err`, no request issued.

## Timing
- Reset values: all outputs 0, `C2F_ReqOpcodeQ500H`=`WR`, `C2F_ReqThreadIDQ500H`=`THREAD_ID`. State IDLE, counters 0. Reset mid-command discards everything.
- The last command byte is sampled at edge N; `C2F_ReqValidQ500H` is high from N+1 and stays high through the first unstalled cycle. Exactly one valid-and-unstalled cycle per command.
- Matching response sampled at edge M: `tx_byte_valid`=1 with data[31:24] from M+1.
- `tx_byte`/`tx_byte_valid` are stable while `tx_ready`=0. The next byte is offered in the cycle after the handshake (no bubble required beyond that).
- A timeout and a byte arriving in the same cycle: the byte wins and the counter clears.
- Request outputs are registered, with no combinational path from any input.

## Structure
- `t_opcode` (WR, RD, RD_RSP) is taken from `lotr_pkg`. Add to `lotr_pkg`: `UART_CMD_WR`=8'h57, `UART_CMD_RD`=8'h52, and the state enum `t_uart_cmd_state`.
- Single module; no sub-module needed. The timeout counter is inline with width `$clog2(BYTE_TIMEOUT+1)`.

## Test plan
- Bytes 57,00,00,10,04,DE,AD,BE,EF -> one cycle of `WR`, addr 0x00001004, data 0xDEADBEEF, tid 0.
- Bytes 52,00,00,20,00; response RD_RSP tid0 data 0x12345678 -> `RD` addr 0x00002000, then tx bytes 12,34,56,78 in order.
- Same write with `C2F_RspStall` high for 5 cycles -> request held 6 cycles with unchanged fields, issued once.
- `tx_ready` toggling 1-of-3 cycles during SEND -> bytes unchanged while stalled, no byte lost or duplicated.
- Bytes 57,00,01 then silence > `BYTE_TIMEOUT` -> no request, `cmd_err`=1, and a following valid `R` command executes normally.
- Byte 0x41 in IDLE, and a RD_RSP with tid 1 during WAIT_RSP -> both ignored, `cmd_err`=1, and the state stays in WAIT_RSP.
